logo_row_fetcher: RTL and testbench

LOGO_ROW_FETCHER -- requirements
Module: logo_row_fetcher

---
 rtl/logo_row_fetcher.sv | 113 +++++++++++
 tb/tb_logo_row_fetcher.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/logo_row_fetcher.sv
// Double-buffered logo row fetcher: streams one 32-bit logo row from ROM per display line
// into a back buffer while the front buffer drives the registered pixel output.
module logo_row_fetcher #(
    parameter int LOGO_X0    = 304,
    parameter int LOGO_Y0    = 224,
    parameter int SCALE_LOG2 = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_line,
    input  logic [9:0] next_y,
    input  logic [9:0] pixel_x,
    input  logic       active,
    output logic [9:0] rom_addr,
    input  logic       rom_data,
    output logic       pixel_on,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [9:0] X0   = 10'(LOGO_X0);
    localparam logic [9:0] Y0   = 10'(LOGO_Y0);
    localparam logic [9:0] YLIM = 10'(30 << SCALE_LOG2);
    localparam logic [9:0] XLIM = 10'(32 << SCALE_LOG2);

    state_t      state;
    state_t      state_next;
    logic [31:0] front;
    logic [31:0] back;
    logic        front_valid;
    logic        back_valid;
    logic [4:0]  row;
    logic [4:0]  col;

    logic [9:0]  ly;
    logic [9:0]  dx;
    logic        ly_hit;
    logic        dx_hit;
    logic [4:0]  ly_row;
    logic [4:0]  dx_col;

    // Unsigned wrap pushes coordinates left of / above the logo out of range.
    assign ly     = next_y - Y0;
    assign dx     = pixel_x - X0;
    assign ly_hit = (ly < YLIM);
    assign dx_hit = (dx < XLIM);
    assign ly_row = 5'(ly >> SCALE_LOG2);
    assign dx_col = 5'(dx >> SCALE_LOG2);

    // Row is always below 30 and col stops at 31, so the address stays below 960
    // and simply holds its last value once the fetch ends.
    assign rom_addr = {row, col};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state == FETCH);
        if (new_line) begin
            state_next = ly_hit ? FETCH : IDLE;
        end else if ((state == FETCH) && (col == 5'd31)) begin
            state_next = IDLE;
        end
    end

    // A new line always promotes back to front, even a half-filled one; back_valid
    // is 0 throughout a fetch, so an aborted row lands in front marked invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            front       <= '0;
            back        <= '0;
            front_valid <= 1'b0;
            back_valid  <= 1'b0;
            row         <= '0;
            col         <= '0;
            pixel_on    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            pixel_on <= active & front_valid & dx_hit & front[dx_col];
            if (new_line) begin
                front       <= back;
                front_valid <= back_valid;
                back_valid  <= 1'b0;
                if (state == FETCH) begin
                    overrun <= 1'b1;
                end
                if (ly_hit) begin
                    row <= ly_row;
                    col <= 5'd0;
                end
            end else if (state == FETCH) begin
                back[col] <= rom_data;
                if (col == 5'd31) begin
                    back_valid <= 1'b1;
                end else begin
                    col <= col + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_logo_row_fetcher.sv
// Self-checking bench for logo_row_fetcher: fetch timing, row display, out-of-range
// lines, overrun recovery and reset abandoning a fetch.
module tb_logo_row_fetcher;

    logic       clk = 1'b0;
    logic       reset;
    logic       newLine;
    logic [9:0] nextY;
    logic [9:0] pixelX;
    logic       active;
    logic [9:0] romAddr;
    logic       romData;
    logic       pixelOn;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       act;
        logic [9:0] px;
        logic       exp;
    } vec_t;

    vec_t  vecs[15];
    logic  expQ[$];
    string nameQ[$];

    // Row 0 has bits 8 and 10..13 set; every other row lights its even columns.
    logic [31:0] row0Bits = 32'h0000_3D00;

    always #5 clk = ~clk;

    logo_row_fetcher dut (
        .clk      (clk),
        .reset    (reset),
        .new_line (newLine),
        .next_y   (nextY),
        .pixel_x  (pixelX),
        .active   (active),
        .rom_addr (romAddr),
        .rom_data (romData),
        .pixel_on (pixelOn),
        .busy     (busy),
        .overrun  (overrun)
    );

    function automatic logic romBit(input logic [9:0] a);
        if (a < 10'd32) begin
            return row0Bits[a[4:0]];
        end
        return ~a[0];
    endfunction

    assign romData = romBit(romAddr);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startLine(input logic [9:0] y);
        newLine = 1'b1;
        nextY   = y;
        tick();
        newLine = 1'b0;
    endtask

    // Drive one pixel, queue its expected value, and compare once the registered output appears.
    task automatic applyStimulus(input logic act, input logic [9:0] px, input logic exp, input string name);
        logic  e;
        string n;
        active = act;
        pixelX = px;
        expQ.push_back(exp);
        nameQ.push_back(name);
        tick();
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, {31'd0, pixelOn}, {31'd0, e});
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (romAddr >= 10'd960) begin
                errors++;
                $display("[TB] FAIL rom_addr_range: got %0d expected below 960", romAddr);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 10'd303, 1'b0};
        vecs[1]  = '{1'b1, 10'd304, 1'b0};
        vecs[2]  = '{1'b1, 10'd320, 1'b1};
        vecs[3]  = '{1'b1, 10'd321, 1'b1};
        vecs[4]  = '{1'b1, 10'd322, 1'b0};
        vecs[5]  = '{1'b1, 10'd323, 1'b0};
        vecs[6]  = '{1'b1, 10'd324, 1'b1};
        vecs[7]  = '{1'b1, 10'd327, 1'b1};
        vecs[8]  = '{1'b1, 10'd331, 1'b1};
        vecs[9]  = '{1'b1, 10'd332, 1'b0};
        vecs[10] = '{1'b1, 10'd367, 1'b0};
        vecs[11] = '{1'b1, 10'd368, 1'b0};
        vecs[12] = '{1'b0, 10'd320, 1'b0};
        vecs[13] = '{1'b0, 10'd325, 1'b0};
        vecs[14] = '{1'b1, 10'd0,   1'b0};

        reset   = 1'b1;
        newLine = 1'b1;
        nextY   = 10'd224;
        active  = 1'b0;
        pixelX  = 10'd0;
        tick();
        tick();
        checkOutput("reset_busy", {31'd0, busy}, 0);
        checkOutput("reset_rom_addr", {22'd0, romAddr}, 0);
        checkOutput("reset_pixel_on", {31'd0, pixelOn}, 0);
        checkOutput("reset_overrun", {31'd0, overrun}, 0);
        reset   = 1'b0;
        newLine = 1'b0;
        tick();
        checkOutput("new_line_during_reset_ignored", {31'd0, busy}, 0);

        $display("[TB] fetch row 0");
        startLine(10'd224);
        for (int k = 0; k < 32; k++) begin
            checkOutput("fetch0_busy", {31'd0, busy}, 1);
            checkOutput("fetch0_rom_addr", {22'd0, romAddr}, k);
            tick();
        end
        checkOutput("fetch0_done_busy", {31'd0, busy}, 0);
        checkOutput("idle_rom_addr_hold", {22'd0, romAddr}, 31);
        tick();
        checkOutput("idle_rom_addr_hold2", {22'd0, romAddr}, 31);

        $display("[TB] display row 0 while refetching it");
        startLine(10'd225);
        checkOutput("refetch_busy", {31'd0, busy}, 1);
        checkOutput("refetch_rom_addr", {22'd0, romAddr}, 0);
        active = 1'b1;
        pixelX = 10'd319;
        tick();
        pixelX = 10'd320;
        checkOutput("latency_old_value", {31'd0, pixelOn}, 0);
        tick();
        checkOutput("latency_new_value", {31'd0, pixelOn}, 1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].act, vecs[i].px, vecs[i].exp, "vector");
        end
        for (int px = 300; px <= 370; px++) begin
            applyStimulus(1'b1, 10'(px), (px == 320) || (px == 321) || (px >= 324 && px <= 331), "sweep_row0");
        end

        $display("[TB] last row and first out-of-range line");
        startLine(10'd283);
        for (int k = 0; k < 32; k++) begin
            checkOutput("fetch29_busy", {31'd0, busy}, 1);
            checkOutput("fetch29_rom_addr", {22'd0, romAddr}, 928 + k);
            tick();
        end
        startLine(10'd284);
        checkOutput("no_fetch_busy", {31'd0, busy}, 0);
        applyStimulus(1'b1, 10'd304, 1'b1, "row29_col0");
        applyStimulus(1'b1, 10'd305, 1'b1, "row29_col0_scaled");
        applyStimulus(1'b1, 10'd306, 1'b0, "row29_col1");
        checkOutput("no_fetch_busy_later", {31'd0, busy}, 0);
        startLine(10'd285);
        applyStimulus(1'b1, 10'd304, 1'b0, "dark_after_no_fetch");
        checkOutput("overrun_still_clear", {31'd0, overrun}, 0);

        $display("[TB] new line mid-fetch");
        startLine(10'd224);
        repeat (10) tick();
        checkOutput("overrun_before", {31'd0, overrun}, 0);
        startLine(10'd226);
        checkOutput("overrun_set", {31'd0, overrun}, 1);
        checkOutput("overrun_busy", {31'd0, busy}, 1);
        for (int k = 0; k < 32; k++) begin
            checkOutput("restart_rom_addr", {22'd0, romAddr}, 32 + k);
            applyStimulus(1'b1, 10'd320, 1'b0, "dark_after_overrun");
        end
        checkOutput("restart_done_busy", {31'd0, busy}, 0);
        checkOutput("overrun_sticky", {31'd0, overrun}, 1);
        startLine(10'd227);
        applyStimulus(1'b1, 10'd304, 1'b1, "row1_col0");
        applyStimulus(1'b1, 10'd306, 1'b0, "row1_col1");
        repeat (32) tick();

        $display("[TB] reset mid-fetch");
        startLine(10'd224);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 10'd320, 1'b1, "pre_reset_row1");
        end
        checkOutput("pre_reset_rom_addr", {22'd0, romAddr}, 5);
        reset = 1'b1;
        tick();
        checkOutput("mid_reset_busy", {31'd0, busy}, 0);
        checkOutput("mid_reset_rom_addr", {22'd0, romAddr}, 0);
        checkOutput("mid_reset_pixel_on", {31'd0, pixelOn}, 0);
        checkOutput("mid_reset_overrun", {31'd0, overrun}, 0);
        reset = 1'b0;
        startLine(10'd225);
        applyStimulus(1'b1, 10'd320, 1'b0, "dark_after_reset");
        applyStimulus(1'b1, 10'd324, 1'b0, "dark_after_reset2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
